multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencer for the RV32I core. It owns the PC and the instruction register (IR) and feeds the IR to `decode`. From `decode`'s format flags, the IR opcode field and the branch-compare result, it steps each instruction through fetch, decode, execute, memory and writeback. Instruction and data memory are reached through req/ack handshakes, each guarded by a timeout. Any illegal condition parks the core in a sticky trap state.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `MEM_TIMEOUT`, default 16: maximum cycles to wait for an ack; 0 disables the timeout.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  instruction fetch request at address `pc`.
- `imem_ack`  in  1  fetch complete; `imem_rdata` is valid this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `ir`  out  32  instruction register; drives `decode.instruction`.
- `is_r`, `is_i`, `is_s`, `is_b`, `is_u`, `is_j`, `incorrect`  in  1 each  format flags from `decode`.
- `br_taken`  in  1  branch condition from the datapath comparator.
- `br_target`  in  32  pc+imm, used by branches and JAL.
- `jalr_target`  in  32  rs1+imm, used by JALR.
- `dmem_req`  out  1  data memory request.
- `dmem_we`  out  1  1 = store; valid while `dmem_req` is high.
- `dmem_ack`  in  1  data access complete.
- `pc`  out  32  current PC.
- `rf_we`  out  1  register-file write strobe.
- `wb_sel`  out  2  writeback source: 0 = ALU, 1 = memory, 2 = pc+4.
- `retired`  out  1  one-cycle pulse when an instruction completes.
- `instret`  out  32  count of retired instructions.
- `trap`  out  1  sticky fault flag.
- `state`  out  3  current FSM state, for debug.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- **FETCH**
  - `imem_req` stays high until `imem_ack`.
  - An ack in the same cycle as the request is legal.
  - On ack: `ir` <= `imem_rdata`, go to DECODE.
- **DECODE**
  - One cycle; the flags are read combinationally from `ir`.
  - If `incorrect` is set, or no format flag is set: go to TRAP.
  - Otherwise go to EXEC.
- **EXEC** (one cycle), by opcode `ir[6:0]`:
  - Load (0000011) or store (0100011): go to MEM.
  - Branch: if `br_taken`, next PC = `br_target`, else pc+4. Write PC, pulse `retired`, go to FETCH.
  - Anything else: go to WB.
- **MEM**
  - `dmem_req` stays high, with `dmem_we` = 1 for a store, until `dmem_ack`.
  - Store: on ack, PC <= pc+4, pulse `retired`, go to FETCH.
  - Load: on ack, go to WB.
- **WB** (one cycle)
  - `rf_we` = 1.
  - `wb_sel`: 1 for a load, 2 for JAL/JALR, else 0.
  - PC update: JAL -> `br_target`; JALR -> `jalr_target & ~1`; else pc+4.
  - Pulse `retired`, go to FETCH.
- **TRAP**
  - Absorbing until reset.
  - `trap` = 1; all strobes, `rf_we` and `retired` held at 0.
  - PC and IR are frozen.
- Misaligned target: a new PC with bits [1:0] != 0 is not written. Go to TRAP instead, with no retire and no `rf_we`.
- Arithmetic:
  - pc+4 wraps modulo 2^32.
  - `instret` wraps from 32'hFFFF_FFFF to 0.
- Spurious acks (ack with no request high) are ignored.

## Timing
- Reset values:
  - `state` = FETCH, `pc` = RESET_PC, `ir` = 0, `instret` = 0, `trap` = 0.
  - `rf_we`, `retired`, `dmem_req`, `dmem_we` = 0; `wb_sel` = 0.
  - `imem_req` rises in the first cycle after reset release.
- Asserting reset mid-handshake drops `imem_req` and `dmem_req` immediately (asynchronous clear).
- Strobes are Moore outputs decoded from state and `ir`. `pc`, `ir` and `instret` update at the rising edge that leaves the state.
- Cycles per instruction with zero-wait acks: branch 3, ALU/LUI/AUIPC/JAL/JALR 4, store 4, load 5. Each wait cycle adds 1.
- Timeout:
  - Counting starts at the first cycle a request is high.
  - An ack arriving on any cycle up to and including cycle MEM_TIMEOUT is accepted.
  - No ack by the end of cycle MEM_TIMEOUT: TRAP at the next edge.
  - The counter clears on every state entry.

## Structure
- Package `mc_pkg` holds:
  - the `state_t` enum (3-bit);
  - opcode localparams: LOAD, STORE, BRANCH, JAL, JALR, OP, OP_IMM, LUI, AUIPC;
  - the `wb_sel` encoding.
- Sub-module `mem_wait_timer`: per-request cycle counter with `start`/`ack` inputs and an `expired` output. The FSM instantiates it once and uses it for both fetch and data accesses.
- `decode` is instantiated by the parent, not inside this block.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-FETCH -> `imem_req` = 0 at once. On release: `pc` = RESET_PC, `instret` = 0, `state` = FETCH.
- **ALU op:** fetch 32'h01010113 (addi) with zero-wait ack -> `rf_we` high in the 4th cycle, `wb_sel` = 0, `pc` 0 -> 4, `retired` pulses once, `instret` = 1.
- **Branch:** fetch 32'h00010463 (beq) with `br_taken` = 1 and `br_target` = 8 -> `pc` = 8 after 3 cycles, no `rf_we`. Repeat with `br_taken` = 0 -> `pc` = pc+4.
- **Load and store:**
  - Load 32'h00012083 with `dmem_ack` delayed 3 cycles -> `dmem_we` = 0, then `rf_we` with `wb_sel` = 1, total 8 cycles.
  - Store 32'h00112023 -> `dmem_we` = 1, no `rf_we`.
- **Illegal instruction:** fetch 32'h00000000 (`incorrect` = 1) -> TRAP after DECODE, `trap` = 1 sticky, `instret` unchanged, no further `imem_req`.
- **Timeout and misalignment:**
  - Hold `imem_ack` = 0 for 16 cycles -> TRAP.
  - Ack on cycle 16 instead -> accepted, no trap.
  - JALR with `jalr_target` = 32'h0000_0006 -> TRAP, `pc` unchanged.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I sequencer.
package mc_pkg;

    // state | meaning
    // FETCH  | instruction request outstanding on imem
    // DECODE | format flags from decode evaluated against ir
    // EXEC   | branch resolved / next PC chosen / memory op launched
    // MEM    | data request outstanding on dmem
    // WB     | register-file write, PC update, retire
    // TRAP   | sticky fault, left only through reset
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction and data memory handshakes seen by the sequencer.
interface multicycle_ctrl_if;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ack, imem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ack, imem_rdata, dmem_ack
    );
endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Per-request wait timer: start marks the first request cycle, expired is
// raised in request cycle MEM_TIMEOUT when no ack has arrived.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic ack,
    output logic expired
);
    localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] TOP = (MEM_TIMEOUT == 0) ? '0 : CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_cur;

    // start overrides the stale count so the first request cycle sees TOP
    assign cnt_cur = start ? TOP : cnt;
    assign expired = (MEM_TIMEOUT != 0) && (cnt_cur == '0) && !ack;

    // down-count remaining request cycles, parking at terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt_cur != '0) begin
            cnt <= cnt_cur - CW'(1);
        end else begin
            cnt <= cnt_cur;
        end
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: owns PC/IR and steps each instruction
// through fetch, decode, execute, memory and writeback.
module multicycle_ctrl import mc_pkg::*; #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multicycle_ctrl_if.master        mem,
    output logic [31:0]              ir,
    input  logic                     is_r,
    input  logic                     is_i,
    input  logic                     is_s,
    input  logic                     is_b,
    input  logic                     is_u,
    input  logic                     is_j,
    input  logic                     incorrect,
    input  logic                     br_taken,
    input  logic [31:0]              br_target,
    input  logic [31:0]              jalr_target,
    output logic [31:0]              pc,
    output logic                     rf_we,
    output logic [1:0]               wb_sel,
    output logic                     retired,
    output logic [31:0]              instret,
    output logic                     trap,
    output logic [2:0]               state
);
    state_t      st;
    logic [6:0]  opcode;
    logic [31:0] pc_plus4;
    logic [31:0] exec_tgt;
    logic [31:0] pc_next;
    logic        any_fmt;
    logic        tmr_start;
    logic        tmr_ack;
    logic        tmr_expired;

    assign opcode   = ir[6:0];
    assign pc_plus4 = pc + 32'd4;
    assign any_fmt  = is_r | is_i | is_s | is_b | is_u | is_j;
    assign state    = st;
    assign tmr_ack  = (st == MEM) ? mem.dmem_ack : mem.imem_ack;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (tmr_start),
        .ack     (tmr_ack),
        .expired (tmr_expired)
    );

    // next PC chosen in EXEC for branches and the writeback path
    always_comb begin
        exec_tgt = pc_plus4;
        if (opcode == BRANCH) begin
            exec_tgt = br_taken ? br_target : pc_plus4;
        end else if (opcode == JAL) begin
            exec_tgt = br_target;
        end else if (opcode == JALR) begin
            exec_tgt = jalr_target & ~32'd1;
        end
    end

    // sequencer FSM; every output is registered on the edge entering its state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st           <= FETCH;
            pc           <= RESET_PC;
            pc_next      <= '0;
            ir           <= '0;
            instret      <= '0;
            mem.imem_req <= 1'b0;
            mem.dmem_req <= 1'b0;
            mem.dmem_we  <= 1'b0;
            rf_we        <= 1'b0;
            wb_sel       <= WB_ALU;
            retired      <= 1'b0;
            trap         <= 1'b0;
            tmr_start    <= 1'b0;
        end else begin
            retired   <= 1'b0;
            tmr_start <= 1'b0;
            case (st)
                FETCH: begin
                    if (!mem.imem_req) begin
                        // first fetch after reset raises the request here
                        mem.imem_req <= 1'b1;
                        tmr_start    <= 1'b1;
                    end else if (mem.imem_ack) begin
                        ir           <= mem.imem_rdata;
                        mem.imem_req <= 1'b0;
                        st           <= DECODE;
                    end else if (tmr_expired) begin
                        mem.imem_req <= 1'b0;
                        trap         <= 1'b1;
                        st           <= TRAP;
                    end
                end
                DECODE: begin
                    if (incorrect || !any_fmt) begin
                        trap <= 1'b1;
                        st   <= TRAP;
                    end else begin
                        st <= EXEC;
                    end
                end
                EXEC: begin
                    if (opcode == LOAD || opcode == STORE) begin
                        mem.dmem_req <= 1'b1;
                        mem.dmem_we  <= (opcode == STORE);
                        tmr_start    <= 1'b1;
                        st           <= MEM;
                    end else if (misaligned(exec_tgt)) begin
                        // caught here so WB never strobes rf_we for a bad target
                        trap <= 1'b1;
                        st   <= TRAP;
                    end else if (opcode == BRANCH) begin
                        pc           <= exec_tgt;
                        instret      <= instret + 32'd1;
                        retired      <= 1'b1;
                        mem.imem_req <= 1'b1;
                        tmr_start    <= 1'b1;
                        st           <= FETCH;
                    end else begin
                        pc_next <= exec_tgt;
                        rf_we   <= 1'b1;
                        wb_sel  <= (opcode == JAL || opcode == JALR) ? WB_PC4 : WB_ALU;
                        st      <= WB;
                    end
                end
                MEM: begin
                    if (mem.dmem_ack) begin
                        mem.dmem_req <= 1'b0;
                        mem.dmem_we  <= 1'b0;
                        if (misaligned(pc_plus4)) begin
                            trap <= 1'b1;
                            st   <= TRAP;
                        end else if (opcode == STORE) begin
                            pc           <= pc_plus4;
                            instret      <= instret + 32'd1;
                            retired      <= 1'b1;
                            mem.imem_req <= 1'b1;
                            tmr_start    <= 1'b1;
                            st           <= FETCH;
                        end else begin
                            pc_next <= pc_plus4;
                            rf_we   <= 1'b1;
                            wb_sel  <= WB_MEM;
                            st      <= WB;
                        end
                    end else if (tmr_expired) begin
                        mem.dmem_req <= 1'b0;
                        mem.dmem_we  <= 1'b0;
                        trap         <= 1'b1;
                        st           <= TRAP;
                    end
                end
                WB: begin
                    pc           <= pc_next;
                    instret      <= instret + 32'd1;
                    retired      <= 1'b1;
                    rf_we        <= 1'b0;
                    wb_sel       <= WB_ALU;
                    mem.imem_req <= 1'b1;
                    tmr_start    <= 1'b1;
                    st           <= FETCH;
                end
                TRAP: begin
                end
                default: begin
                    mem.imem_req <= 1'b0;
                    mem.dmem_req <= 1'b0;
                    mem.dmem_we  <= 1'b0;
                    rf_we        <= 1'b0;
                    trap         <= 1'b1;
                    st           <= TRAP;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with a retire/writeback scoreboard.
module tb_multicycle_ctrl;
    import mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ir;
    logic        is_r, is_i, is_s, is_b, is_u, is_j, incorrect;
    logic        br_taken;
    logic [31:0] br_target, jalr_target;
    logic [31:0] pc;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        retired;
    logic [31:0] instret;
    logic        trap;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instret;
    } ret_t;

    ret_t       ret_q[$];
    logic [1:0] wb_q[$];

    multicycle_ctrl_if mif();

    multicycle_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem         (mif),
        .ir          (ir),
        .is_r        (is_r),
        .is_i        (is_i),
        .is_s        (is_s),
        .is_b        (is_b),
        .is_u        (is_u),
        .is_j        (is_j),
        .incorrect   (incorrect),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jalr_target (jalr_target),
        .pc          (pc),
        .rf_we       (rf_we),
        .wb_sel      (wb_sel),
        .retired     (retired),
        .instret     (instret),
        .trap        (trap),
        .state       (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // stands in for the parent's decode instance
    always_comb begin
        {is_r, is_i, is_s, is_b, is_u, is_j, incorrect} = 7'b0;
        case (ir[6:0])
            OP:                  is_r = 1'b1;
            OP_IMM, LOAD, JALR:  is_i = 1'b1;
            STORE:               is_s = 1'b1;
            BRANCH:              is_b = 1'b1;
            LUI, AUIPC:          is_u = 1'b1;
            JAL:                 is_j = 1'b1;
            default:             incorrect = 1'b1;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // scoreboard: every retire and every rf_we must match a queued expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (retired === 1'b1) begin
                chk("retire_expected", 32'(ret_q.size() > 0), 32'd1);
                if (ret_q.size() > 0) begin
                    ret_t e;
                    e = ret_q.pop_front();
                    chk("ret_pc", pc, e.pc);
                    chk("ret_instret", instret, e.instret);
                end
            end
            if (rf_we === 1'b1) begin
                chk("rf_we_expected", 32'(wb_q.size() > 0), 32'd1);
                if (wb_q.size() > 0) begin
                    logic [1:0] w;
                    w = wb_q.pop_front();
                    chk("wb_sel", {30'd0, wb_sel}, {30'd0, w});
                end
            end
        end
    end

    task automatic do_fetch(input logic [31:0] instr, input int waits, output int t0);
        int n = 0;
        while (mif.imem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req_seen", {31'd0, mif.imem_req}, 32'd1);
        t0 = cyc;
        repeat (waits) @(negedge clk);
        mif.imem_rdata = instr;
        mif.imem_ack   = 1'b1;
        @(negedge clk);
        mif.imem_ack   = 1'b0;
        mif.imem_rdata = '0;
    endtask

    task automatic do_mem(input int waits, input logic we_exp);
        int n = 0;
        while (mif.dmem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("dmem_req_seen", {31'd0, mif.dmem_req}, 32'd1);
        chk("dmem_we", {31'd0, mif.dmem_we}, {31'd0, we_exp});
        repeat (waits) @(negedge clk);
        mif.dmem_ack = 1'b1;
        @(negedge clk);
        mif.dmem_ack = 1'b0;
    endtask

    // leaves the bench on the retire cycle, which is also the next fetch's first cycle
    task automatic expect_latency(input string tag, input int t0, input int n_exp);
        int n = 0;
        while (retired !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(tag, cyc - t0, n_exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic any_req;

        rst_n          = 1'b0;
        mif.imem_ack   = 1'b0;
        mif.imem_rdata = '0;
        mif.dmem_ack   = 1'b0;
        br_taken       = 1'b0;
        br_target      = '0;
        jalr_target    = '0;

        repeat (3) @(negedge clk);
        chk("rst_state", {29'd0, state}, {29'd0, FETCH});
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_instret", instret, 32'h0);
        chk("rst_trap", {31'd0, trap}, 32'd0);
        chk("rst_imem_req", {31'd0, mif.imem_req}, 32'd0);
        chk("rst_dmem_req", {31'd0, mif.dmem_req}, 32'd0);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_wb_sel", {30'd0, wb_sel}, 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        chk("req_after_release", {31'd0, mif.imem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("req_async_clear", {31'd0, mif.imem_req}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("release_pc", pc, 32'h0);
        chk("release_state", {29'd0, state}, {29'd0, FETCH});
        chk("release_instret", instret, 32'h0);

        // addi: WB in the 4th request cycle
        ret_q.push_back('{pc: 32'h4, instret: 32'd1});
        wb_q.push_back(WB_ALU);
        do_fetch(32'h01010113, 0, t0);
        @(negedge clk);
        @(negedge clk);
        chk("alu_rf_we_c4", {31'd0, rf_we}, 32'd1);
        expect_latency("alu_cpi", t0, 4);

        // beq taken then not taken
        br_taken  = 1'b1;
        br_target = 32'h8;
        ret_q.push_back('{pc: 32'h8, instret: 32'd2});
        do_fetch(32'h00010463, 0, t0);
        expect_latency("br_taken_cpi", t0, 3);
        chk("br_taken_pc", pc, 32'h8);
        br_taken = 1'b0;
        ret_q.push_back('{pc: 32'hC, instret: 32'd3});
        do_fetch(32'h00010463, 0, t0);
        expect_latency("br_not_taken_cpi", t0, 3);

        // load with three wait cycles, then zero-wait store
        ret_q.push_back('{pc: 32'h10, instret: 32'd4});
        wb_q.push_back(WB_MEM);
        do_fetch(32'h00012083, 0, t0);
        do_mem(3, 1'b0);
        expect_latency("load_cpi", t0, 8);
        ret_q.push_back('{pc: 32'h14, instret: 32'd5});
        do_fetch(32'h00112023, 0, t0);
        do_mem(0, 1'b1);
        expect_latency("store_cpi", t0, 4);

        // jal and jalr (bit 0 of jalr target cleared)
        br_target = 32'h40;
        ret_q.push_back('{pc: 32'h40, instret: 32'd6});
        wb_q.push_back(WB_PC4);
        do_fetch(32'h0080006F, 0, t0);
        expect_latency("jal_cpi", t0, 4);
        jalr_target = 32'h45;
        ret_q.push_back('{pc: 32'h44, instret: 32'd7});
        wb_q.push_back(WB_PC4);
        do_fetch(32'h000080E7, 0, t0);
        expect_latency("jalr_cpi", t0, 4);

        // fetch ack on request cycle 16 is still accepted
        ret_q.push_back('{pc: 32'h48, instret: 32'd8});
        wb_q.push_back(WB_ALU);
        do_fetch(32'h01010113, 15, t0);
        expect_latency("ack_c16_cpi", t0, 19);
        chk("ack_c16_no_trap", {31'd0, trap}, 32'd0);

        // misaligned jalr target traps with pc and instret frozen
        jalr_target = 32'h6;
        do_fetch(32'h000080E7, 0, t0);
        @(negedge clk);
        @(negedge clk);
        chk("misalign_state", {29'd0, state}, {29'd0, TRAP});
        chk("misalign_trap", {31'd0, trap}, 32'd1);
        chk("misalign_pc", pc, 32'h48);
        chk("misalign_instret", instret, 32'd8);

        // fetch timeout
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_clears_trap", {31'd0, trap}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("timeout_req_c1", {31'd0, mif.imem_req}, 32'd1);
        repeat (15) @(negedge clk);
        chk("timeout_c16_state", {29'd0, state}, {29'd0, FETCH});
        @(negedge clk);
        chk("timeout_trap", {31'd0, trap}, 32'd1);
        chk("timeout_state", {29'd0, state}, {29'd0, TRAP});
        chk("timeout_req_low", {31'd0, mif.imem_req}, 32'd0);

        // illegal instruction, with spurious acks while trapped
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_fetch(32'h00000000, 0, t0);
        @(negedge clk);
        chk("illegal_state", {29'd0, state}, {29'd0, TRAP});
        chk("illegal_trap", {31'd0, trap}, 32'd1);
        chk("illegal_instret", instret, 32'd0);
        any_req = 1'b0;
        mif.imem_ack = 1'b1;
        mif.dmem_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            any_req = any_req | mif.imem_req | mif.dmem_req;
        end
        mif.imem_ack = 1'b0;
        mif.dmem_ack = 1'b0;
        chk("trap_no_req", {31'd0, any_req}, 32'd0);
        chk("trap_sticky", {31'd0, trap}, 32'd1);
        chk("trap_pc_frozen", pc, 32'h0);

        chk("ret_q_drained", ret_q.size(), 32'd0);
        chk("wb_q_drained", wb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
